// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: valid/ready capture, hex decode with
// leading-zero blanking, per-digit dp/blink, static bus plus multiplexed scan.
//
//   state  | meaning
//   S_IDLE | stage 1 empty, in_ready high, waiting for a transfer
//   S_FULL | stage 1 holds captured data, stage 2 loads on the next edge
module seg_display_ctrl #(
   parameter int NDIGITS    = 8,
   parameter int BLINK_DIV  = 25000000,
   parameter int SCAN_DIV   = 50000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NDIGITS-1:0]   in_value,
   input  logic [NDIGITS-1:0]     in_dp,
   input  logic [NDIGITS-1:0]     in_blink,
   input  logic                   in_lzb,
   output logic [8*NDIGITS-1:0]   seg_flat,
   output logic [7:0]             scan_seg,
   output logic [NDIGITS-1:0]     scan_an
);

   localparam int BW = ($clog2(BLINK_DIV) < 1) ? 1 : $clog2(BLINK_DIV);
   localparam int SW = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
   localparam int IW = ($clog2(NDIGITS) < 1) ? 1 : $clog2(NDIGITS);
   localparam logic [7:0]         SEG_OFF = {8{ACTIVE_LOW}};
   localparam logic [NDIGITS-1:0] AN_OFF  = {NDIGITS{ACTIVE_LOW}};

   typedef enum logic {S_IDLE, S_FULL} state_t;

   state_t                 state, state_nxt;
   logic                   load_s1, load_s2;

   logic [4*NDIGITS-1:0]   s1_value;
   logic [NDIGITS-1:0]     s1_dp, s1_blink;
   logic                   s1_lzb;

   logic [8*NDIGITS-1:0]   dec_seg;
   logic [8*NDIGITS-1:0]   s2_seg;
   logic [NDIGITS-1:0]     s2_blink;

   logic [BW-1:0]          blink_cnt;
   logic                   blink_hidden;
   logic [SW-1:0]          scan_cnt;
   logic [IW-1:0]          scan_idx;
   logic [7:0]             scan_byte;
   logic [NDIGITS-1:0]     an_nxt;

   function automatic logic [6:0] hex_pat(input logic [3:0] nib);
      case (nib)
         4'h0:    return 7'b1111110;
         4'h1:    return 7'b0110000;
         4'h2:    return 7'b1101101;
         4'h3:    return 7'b1111001;
         4'h4:    return 7'b0110011;
         4'h5:    return 7'b1011011;
         4'h6:    return 7'b1011111;
         4'h7:    return 7'b1110000;
         4'h8:    return 7'b1111111;
         4'h9:    return 7'b1111011;
         4'hA:    return 7'b1110111;
         4'hB:    return 7'b0011111;
         4'hC:    return 7'b1001110;
         4'hD:    return 7'b0111101;
         4'hE:    return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = S_FULL;
         S_FULL:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == S_IDLE);
      load_s1  = (state == S_IDLE) && in_valid;
      load_s2  = (state == S_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_value <= '0;
         s1_dp    <= '0;
         s1_blink <= '0;
         s1_lzb   <= 1'b0;
      end else if (load_s1) begin
         s1_value <= in_value;
         s1_dp    <= in_dp;
         s1_blink <= in_blink;
         s1_lzb   <= in_lzb;
      end
   end

   // Walk from the most significant digit so upper_zero covers this and all higher nibbles.
   always_comb begin : decode
      logic       upper_zero;
      logic       blank;
      logic [3:0] nib;
      dec_seg    = '0;
      upper_zero = 1'b1;
      blank      = 1'b0;
      nib        = 4'h0;
      for (int k = NDIGITS - 1; k >= 0; k--) begin
         nib        = s1_value[4*k +: 4];
         upper_zero = upper_zero && (nib == 4'h0);
         blank      = s1_lzb && (k != 0) && upper_zero;
         dec_seg[8*k +: 8] = {(blank ? 7'b0 : hex_pat(nib)), s1_dp[k]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_seg   <= '0;
         s2_blink <= '0;
      end else if (load_s2) begin
         s2_seg   <= dec_seg;
         s2_blink <= s1_blink;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt    <= '0;
         blink_hidden <= ~blink_hidden;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb begin
      seg_flat = '0;
      for (int k = 0; k < NDIGITS; k++) begin
         if (s2_blink[k] && blink_hidden) seg_flat[8*k +: 8] = SEG_OFF;
         else if (ACTIVE_LOW)             seg_flat[8*k +: 8] = ~s2_seg[8*k +: 8];
         else                             seg_flat[8*k +: 8] = s2_seg[8*k +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == IW'(NDIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      scan_byte = SEG_OFF;
      an_nxt    = AN_OFF;
      for (int k = 0; k < NDIGITS; k++) begin
         if (scan_idx == IW'(k)) begin
            scan_byte = seg_flat[8*k +: 8];
            an_nxt[k] = ~ACTIVE_LOW;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_seg <= SEG_OFF;
         scan_an  <= AN_OFF;
      end else begin
         scan_seg <= scan_byte;
         scan_an  <= an_nxt;
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: transfers are scored into a queue and a negedge
// monitor compares the display, scan outputs and handshake against a digit model.
module tb_seg_display_ctrl;

   localparam int N  = 4;
   localparam int BD = 4;
   localparam int SD = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_value = '0;
   logic [3:0]    in_dp = '0;
   logic [3:0]    in_blink = '0;
   logic          in_lzb = 1'b0;
   logic [31:0]   seg_flat;
   logic [7:0]    scan_seg;
   logic [3:0]    scan_an;

   seg_display_ctrl #(.NDIGITS(N), .BLINK_DIV(BD), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .in_dp(in_dp), .in_blink(in_blink), .in_lzb(in_lzb),
      .seg_flat(seg_flat), .scan_seg(scan_seg), .scan_an(scan_an)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bytes;
      logic [3:0]  mask;
      int          n_x;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          n = 0;
   int          xfer_total = 0;
   logic        rst_q = 1'b1;
   logic        xfer_q = 1'b0;

   // Segment patterns a..g for hex digits, logical polarity.
   logic [6:0] pat_tbl [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
      end
   endtask

   function automatic logic [31:0] model_bytes(input logic [15:0] v, input logic [3:0] dp,
                                               input logic lzb);
      logic [31:0] r;
      logic [15:0] upper;
      logic [3:0]  nib;
      logic        blank;
      r = '0;
      for (int k = 0; k < N; k++) begin
         nib   = v[4*k +: 4];
         upper = v >> (4 * k);
         blank = lzb && (k > 0) && (upper == 16'h0);
         r[8*k +: 8] = {(blank ? 7'd0 : pat_tbl[nib]), dp[k]};
      end
      return r;
   endfunction

   function automatic logic [31:0] phys_flat(input logic [31:0] bytes, input logic [3:0] mask,
                                             input logic hidden);
      logic [31:0] r;
      r = bytes;
      for (int k = 0; k < N; k++)
         if (mask[k] && hidden) r[8*k +: 8] = 8'h00;
      return ~r;
   endfunction

   // Transfer observer: pushes the expected display for every accepted word.
   initial forever begin
      @(posedge clk);
      rst_q <= rst;
      if (rst) begin
         n      <= 0;
         xfer_q <= 1'b0;
         sb.delete();
      end else begin
         n      <= n + 1;
         xfer_q <= 1'b0;
         if (in_valid && in_ready) begin
            sb.push_back('{model_bytes(in_value, in_dp, in_lzb), in_blink, n + 1});
            xfer_q     <= 1'b1;
            xfer_total <= xfer_total + 1;
         end
      end
   end

   // Monitor: display content changes only when in_ready returns high.
   initial begin : monitor
      logic [31:0] disp_bytes, prev_flat, exp_flat;
      logic [3:0]  disp_mask, one;
      logic        prev_ready, hidden;
      int          idx;
      exp_t        e;
      disp_bytes = '0; disp_mask = '0; prev_flat = '1; prev_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_q) begin
            chk("rst_ready", {31'b0, in_ready}, 32'd1);
            chk("rst_flat", seg_flat, 32'hFFFF_FFFF);
            chk("rst_an", {28'b0, scan_an}, 32'hF);
            chk("rst_scan_seg", {24'b0, scan_seg}, 32'hFF);
            disp_bytes = '0; disp_mask = '0; prev_flat = '1; prev_ready = 1'b1;
         end else begin
            if (!prev_ready) chk("ready_pulse", {31'b0, in_ready}, 32'd1);
            if (in_ready && !prev_ready) begin
               chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("latency", n - e.n_x, 32'd1);
                  disp_bytes = e.bytes;
                  disp_mask  = e.mask;
               end
            end
            if (xfer_q) chk("ready_low", {31'b0, in_ready}, 32'd0);
            hidden   = ((n / BD) % 2) == 1;
            exp_flat = phys_flat(disp_bytes, disp_mask, hidden);
            chk("seg_flat", seg_flat, exp_flat);
            idx = ((n - 1) / SD) % N;
            one = 4'b0001 << idx;
            chk("scan_an", {28'b0, scan_an}, {28'b0, ~one});
            chk("scan_seg", {24'b0, scan_seg}, {24'b0, prev_flat[idx*8 +: 8]});
            prev_flat  = exp_flat;
            prev_ready = in_ready;
         end
      end
   end

   task automatic idle(input int c);
      repeat (c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                       input logic lzb);
      int g;
      in_value = v; in_dp = dp; in_blink = bl; in_lzb = lzb; in_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("send_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int start;
      logic [15:0] v;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      send(16'h12AF, 4'b0000, 4'b0000, 1'b0);
      idle(3);
      send(16'h0030, 4'b1000, 4'b0000, 1'b1);
      idle(2);
      send(16'h0000, 4'b0000, 4'b0000, 1'b1);
      idle(2);
      send(16'h1111, 4'b0000, 4'b0001, 1'b0);
      idle(20);

      start = xfer_total;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_value = 16'($urandom);
         in_dp    = 4'($urandom);
         in_blink = 4'($urandom);
         in_lzb   = 1'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      idle(1);
      chk("b2b_count", xfer_total - start, 32'd3);
      idle(3);

      send(16'hABCD, 4'b0101, 4'b0000, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      idle(6);

      for (int i = 0; i < 40; i++) begin
         v = 16'($urandom);
         if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 4));
         send(v, 4'($urandom), 4'($urandom), 1'($urandom));
         idle($urandom_range(0, 3));
      end
      idle(12);
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller. It accepts a packed hex value through a valid/ready handshake, registers it, and decodes each nibble to segment patterns 0-F. It supports leading-zero blanking, per-digit decimal points and per-digit blinking. It drives both a static per-digit segment bus and a time-multiplexed scan interface (segment bus plus one-hot digit enable) for board display peripherals.

Parameters:
NDIGITS, 8, number of digits (1..8).
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).
SCAN_DIV, 50000, clk cycles each digit is held in scan mode (>=2).
ACTIVE_LOW, 1, 1 = segment and digit-enable outputs are active-low.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  new display data offered.
in_ready  out  1  controller can accept data.
in_value  in  4*NDIGITS  nibble k = digit k; digit 0 is least significant.
in_dp  in  NDIGITS  decimal point on per digit.
in_blink  in  NDIGITS  digit blinks when 1.
in_lzb  in  1  leading-zero blanking enable.
seg_flat  out  8*NDIGITS  static segments; byte k = digit k.
scan_seg  out  8  segments of the currently scanned digit.
scan_an  out  NDIGITS  one-hot digit enable.

Behaviour:
- Reset (rst = 1 at a clk edge) takes priority over all other inputs, including a transfer in the same cycle.
  - Values after reset: in_ready = 1; all captured registers = 0; blink counter = 0; blink phase = visible; scan counter = 0; scan index = 0.
  - seg_flat and scan_seg show all segments off (all 1s if ACTIVE_LOW, else all 0s); scan_an all off.
  - First scan enable appears 1 cycle after reset release, on digit 0.
- Segment byte, logical polarity (1 = lit): bit7 = a, bit6 = b, bit5 = c, bit4 = d, bit3 = e, bit2 = f, bit1 = g, bit0 = dp. When ACTIVE_LOW = 1 the physical output is the inversion.
- Hex patterns, bits 7..1:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- Handshake and pipeline:
  - A transfer occurs on a clk edge with in_valid & in_ready.
  - Cycle T+1: value, dp, blink and lzb are captured into stage 1; in_ready = 0.
  - Cycle T+2: decoded patterns are registered into stage 2 and seg_flat updates; in_ready = 1.
  - Maximum rate is one transfer per 2 cycles. in_valid while in_ready = 0 is ignored (the source must hold it).
  - Without a transfer, the display holds its last data indefinitely.
- Leading-zero blanking, applied at decode when captured lzb = 1:
  - Digit k (k >= 1) is blank if it and all more-significant nibbles are 0.
  - Digit 0 is never blanked by LZB.
  - dp still lights on a blanked digit if its dp bit is set.
- Blink:
  - The counter runs 0..BLINK_DIV-1 and wraps; the phase toggles on each wrap.
  - In the hidden phase, every digit with its blink bit set shows all segments off, including dp.
  - The counter is free-running and unaffected by transfers.
- Scan:
  - The counter runs 0..SCAN_DIV-1; on each wrap the index increments, wrapping NDIGITS-1 -> 0.
  - Outputs are registered: scan_an is one-hot on the index and scan_seg = seg_flat byte[index], both updated the same cycle.
  - NDIGITS = 1 keeps scan_an constantly on.
- Simultaneous events: a blink toggle, scan wrap and stage-2 update in the same cycle all take effect together. seg_flat and scan_seg are never glitched by a partial update.
- Counter widths are $clog2 of the divisor (minimum 1 bit). There is no overflow beyond the wrap.
- Reset mid-pipeline (stage 1 full) discards the pending data.

Test Plan:
- Reset: NDIGITS = 4, ACTIVE_LOW = 1, rst for 3 cycles -> seg_flat = 32'hFFFF_FFFF, scan_an = 4'hF, in_ready = 1.
- Transfer in_value = 16'h12AF, dp = 0, blink = 0, lzb = 0 at edge T -> in_ready = 0 at T+1; at T+2 seg_flat bytes 3..0 = ~8'h60, ~8'hDA, ~8'hEE, ~8'h8E; in_ready = 1.
- LZB: in_value = 16'h0030, lzb = 1, dp = 4'b1000 -> digit3 = ~8'h01 (dp only), digit2 = 8'hFF, digit1 = ~8'hF2, digit0 = ~8'hFC. With in_value = 0, digit0 = ~8'hFC.
- Blink: BLINK_DIV = 4, blink = 4'b0001, value 16'h1111 -> digit0 alternates ~8'h60 / 8'hFF every 4 cycles; digits 1-3 stay constant.
- Scan: SCAN_DIV = 3 -> scan_an sequence 1110, 1101, 1011, 0111, 1110, each held 3 cycles; scan_seg matches the selected byte.
- Back-to-back: in_valid held high for 6 cycles with the value changing every cycle -> exactly 3 transfers, on alternate edges. Reset asserted the cycle after a transfer -> seg_flat stays blank, no update.
